axi_10g_tx_arbiter: RTL and testbench

Parametrised N-channel AXI4-Stream transmit arbiter that sits between the packet generators (ARP request/reply, ICMP reply, TCP link, TCP user) and the 10G MAC TX AXI-Stream port. It grants the MAC to one source for exactly one whole packet, selected by fixed-priority or round-robin arbitration. Output goes through a registered, back-pressure-aware slice that honours the MAC's `tready`. Packet-granular loss injection and packet counters support link testing.

---
 rtl/axi_10g_tx_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_axi_10g_tx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_10g_tx_arbiter.sv
// axi_10g_tx_arbiter
// Packet-granular AXI4-Stream arbiter between NUM_CH packet sources and the
// 10G MAC TX port. A source owns the MAC for one whole packet; the winner is
// chosen by fixed priority (ARB_MODE=0, lowest index wins) or round-robin
// (ARB_MODE=1). Output goes through a single registered slice that honours
// m_axis_tready. A packet whose drop_mask bit is set at grant time is
// swallowed instead of forwarded.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_req                per-channel level request for one packet
//   grant                one-hot owner of the current packet (0 when idle)
//   s_axis_*             packed per-channel source streams (channel c at slot c)
//   drop_mask            loss injection, sampled only when a grant is made
//   m_axis_*             registered stream to the MAC
//   pkt_sent_cnt         packets whose tlast was accepted by the MAC
//   pkt_drop_cnt         packets discarded by loss injection
module axi_10g_tx_arbiter #(
    parameter int NUM_CH   = 5,
    parameter int DATA_W   = 64,
    parameter int KEEP_W   = DATA_W / 8,
    parameter int ARB_MODE = 0,
    parameter int CNT_W    = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUM_CH-1:0]        s_req,
    output logic [NUM_CH-1:0]        grant,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH*KEEP_W-1:0] s_axis_tkeep,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    input  logic [NUM_CH-1:0]        s_axis_tlast,
    output logic [NUM_CH-1:0]        s_axis_tready,
    input  logic [NUM_CH-1:0]        drop_mask,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [KEEP_W-1:0]        m_axis_tkeep,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [CNT_W-1:0]         pkt_sent_cnt,
    output logic [CNT_W-1:0]         pkt_drop_cnt
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [NUM_CH-1:0]   grant_next;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    rr_ptr_next;
    logic [PTR_W-1:0]    cand;
    logic [PTR_W-1:0]    win_idx;
    logic                win_found;
    logic [DATA_W-1:0]   sel_data;
    logic [KEEP_W-1:0]   sel_keep;
    logic                sel_last;
    logic                out_free;
    logic                beat_accept;
    logic                pkt_end;

    // Search order starts at rr_ptr in round-robin mode, at 0 in fixed mode.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ARB_MODE == 1)
                cand = PTR_W'((int'(rr_ptr) + i) % NUM_CH);
            else
                cand = PTR_W'(i);
            if (!win_found && s_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // grant is one-hot, so an OR-reduction acts as the channel mux.
    always_comb begin
        sel_data = '0;
        sel_keep = '0;
        sel_last = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                sel_data = sel_data | s_axis_tdata[c*DATA_W +: DATA_W];
                sel_keep = sel_keep | s_axis_tkeep[c*KEEP_W +: KEEP_W];
                sel_last = sel_last | s_axis_tlast[c];
            end
        end
    end

    assign out_free = !m_axis_tvalid || m_axis_tready;

    always_comb begin
        s_axis_tready = '0;
        case (state)
            SEND:    s_axis_tready = grant & {NUM_CH{out_free}};
            DROP:    s_axis_tready = grant;
            default: s_axis_tready = '0;
        endcase
    end

    assign beat_accept = |(s_axis_tvalid & s_axis_tready);
    assign pkt_end     = beat_accept && sel_last;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_next;
            grant  <= grant_next;
            rr_ptr <= rr_ptr_next;
        end
    end

    // The drop decision is latched by choosing DROP vs SEND at grant time,
    // so later drop_mask changes cannot affect the packet in flight.
    always_comb begin
        state_next  = state;
        grant_next  = grant;
        rr_ptr_next = rr_ptr;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_next = NUM_CH'(1) << win_idx;
                    state_next = drop_mask[win_idx] ? DROP : SEND;
                    if (win_idx == PTR_W'(NUM_CH - 1))
                        rr_ptr_next = '0;
                    else
                        rr_ptr_next = win_idx + PTR_W'(1);
                end
            end
            SEND, DROP: begin
                if (pkt_end) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (state == SEND && beat_accept) begin
            m_axis_tdata  <= sel_data;
            m_axis_tkeep  <= sel_keep;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= sel_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_sent_cnt <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                pkt_sent_cnt <= pkt_sent_cnt + CNT_W'(1);
            if (state == DROP && pkt_end)
                pkt_drop_cnt <= pkt_drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_axi_10g_tx_arbiter.sv
// tb_axi_10g_tx_arbiter
// Directed bench for axi_10g_tx_arbiter. A fixed-priority instance is driven
// by simple per-channel packet sources; a separate round-robin instance has
// every channel permanently offering 1-beat packets so its grant order can
// be observed. Beat payload encodes channel and beat index.
module tb_axi_10g_tx_arbiter;

    localparam int NCH = 5;
    localparam int DW  = 64;
    localparam int KW  = 8;

    logic              aclk;
    logic              aresetn;
    logic              rr_resetn;

    logic [NCH-1:0]    s_req;
    logic [NCH-1:0]    grant;
    logic [NCH*DW-1:0] s_axis_tdata;
    logic [NCH*KW-1:0] s_axis_tkeep;
    logic [NCH-1:0]    s_axis_tvalid;
    logic [NCH-1:0]    s_axis_tlast;
    logic [NCH-1:0]    s_axis_tready;
    logic [NCH-1:0]    drop_mask;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [31:0]       pkt_sent_cnt;
    logic [31:0]       pkt_drop_cnt;

    logic [NCH-1:0]    rr_req;
    logic [NCH-1:0]    rr_grant;
    logic [NCH*DW-1:0] rr_tdata;
    logic [NCH*KW-1:0] rr_tkeep;
    logic [NCH-1:0]    rr_tvalid;
    logic [NCH-1:0]    rr_tlast;
    logic [NCH-1:0]    rr_tready;
    logic [NCH-1:0]    rr_drop;
    logic [DW-1:0]     rr_m_tdata;
    logic [KW-1:0]     rr_m_tkeep;
    logic              rr_m_tvalid;
    logic              rr_m_tlast;
    logic              rr_m_tready;
    logic [31:0]       rr_sent_cnt;
    logic [31:0]       rr_drop_cnt;

    int                checkCount;
    int                errorCount;

    int                src_len    [NCH];
    int                src_beat   [NCH];
    bit                src_active [NCH];
    logic [7:0]        src_lastkeep [NCH];

    axi_10g_tx_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .ARB_MODE(0), .CNT_W(32)) dut_fix (
        .aclk(aclk), .aresetn(aresetn),
        .s_req(s_req), .grant(grant),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .drop_mask(drop_mask),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .pkt_sent_cnt(pkt_sent_cnt), .pkt_drop_cnt(pkt_drop_cnt)
    );

    axi_10g_tx_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .ARB_MODE(1), .CNT_W(32)) dut_rr (
        .aclk(aclk), .aresetn(rr_resetn),
        .s_req(rr_req), .grant(rr_grant),
        .s_axis_tdata(rr_tdata), .s_axis_tkeep(rr_tkeep),
        .s_axis_tvalid(rr_tvalid), .s_axis_tlast(rr_tlast),
        .s_axis_tready(rr_tready), .drop_mask(rr_drop),
        .m_axis_tdata(rr_m_tdata), .m_axis_tkeep(rr_m_tkeep),
        .m_axis_tvalid(rr_m_tvalid), .m_axis_tlast(rr_m_tlast),
        .m_axis_tready(rr_m_tready),
        .pkt_sent_cnt(rr_sent_cnt), .pkt_drop_cnt(rr_drop_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [63:0] beatData(input int c, input int b);
        return {8'(c + 1), 24'h0, 32'(b + 1)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic driveSources();
        for (int c = 0; c < NCH; c++) begin
            logic lastBeat;
            lastBeat = src_active[c] && (src_beat[c] == src_len[c] - 1);
            s_axis_tvalid[c] = src_active[c];
            s_axis_tlast[c]  = lastBeat;
            s_axis_tdata[c*DW +: DW] = src_active[c] ? beatData(c, src_beat[c]) : 64'h0;
            s_axis_tkeep[c*KW +: KW] = !src_active[c] ? 8'h00 : (lastBeat ? src_lastkeep[c] : 8'hFF);
        end
    endtask

    task automatic startPkt(input int c, input int len, input logic [7:0] lastKeep);
        src_len[c]      = len;
        src_beat[c]     = 0;
        src_active[c]   = 1'b1;
        src_lastkeep[c] = lastKeep;
        s_req[c]        = 1'b1;
        driveSources();
    endtask

    // Advance one cycle: handshakes seen before the edge move the sources on,
    // then the MAC ready for the new cycle is applied.
    task automatic applyStimulus(input logic macReady);
        logic [NCH-1:0] fire;
        fire = s_axis_tvalid & s_axis_tready;
        @(posedge aclk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (fire[c]) begin
                if (src_beat[c] == src_len[c] - 1) begin
                    src_active[c] = 1'b0;
                    s_req[c]      = 1'b0;
                end else begin
                    src_beat[c]++;
                end
            end
        end
        driveSources();
        m_axis_tready = macReady;
        #1;
    endtask

    initial begin
        int rrOrder [6];
        logic expValid;
        logic [63:0] expData;
        logic expReady;
        logic [NCH-1:0] expGrant;

        checkCount = 0;
        errorCount = 0;
        rrOrder = '{0, 1, 2, 3, 4, 0};

        aresetn   = 1'b0;
        rr_resetn = 1'b0;
        s_req     = '0;
        drop_mask = '0;
        m_axis_tready = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            src_active[c] = 1'b0;
            src_len[c] = 1;
            src_beat[c] = 0;
            src_lastkeep[c] = 8'hFF;
        end
        driveSources();

        rr_req      = '0;
        rr_tdata    = '0;
        rr_tkeep    = '1;
        rr_tvalid   = '1;
        rr_tlast    = '1;
        rr_drop     = '0;
        rr_m_tready = 1'b1;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("rst grant", 64'(grant), 64'h0);
        checkOutput("rst tready", 64'(s_axis_tready), 64'h0);
        checkOutput("rst m_tvalid", 64'(m_axis_tvalid), 64'h0);
        checkOutput("rst m_tdata", m_axis_tdata, 64'h0);
        checkOutput("rst sent", 64'(pkt_sent_cnt), 64'h0);
        checkOutput("rst drop", 64'(pkt_drop_cnt), 64'h0);
        aresetn   = 1'b1;
        rr_resetn = 1'b1;

        // Round-robin: everyone requests 1-beat packets continuously.
        @(posedge aclk);
        #2;
        rr_req = '1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(posedge aclk);
            #2;
            expGrant = (cyc % 2 == 1) ? (NCH'(1) << rrOrder[(cyc - 1) / 2]) : '0;
            checkOutput($sformatf("rr grant c%0d", cyc), 64'(rr_grant), 64'(expGrant));
        end
        rr_req = '0;

        // Fixed priority: ch1 and ch3 request 3-beat packets together.
        @(posedge aclk);
        #2;
        startPkt(1, 3, 8'hFF);
        startPkt(3, 3, 8'hFF);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            applyStimulus(1'b1);
            expValid = (cyc >= 2 && cyc <= 4) || (cyc >= 6 && cyc <= 8);
            expData  = (cyc <= 4) ? beatData(1, cyc - 2) : beatData(3, cyc - 6);
            checkOutput($sformatf("fix valid c%0d", cyc), 64'(m_axis_tvalid), 64'(expValid));
            if (expValid) begin
                checkOutput($sformatf("fix data c%0d", cyc), m_axis_tdata, expData);
                checkOutput($sformatf("fix last c%0d", cyc), 64'(m_axis_tlast), 64'(cyc == 4 || cyc == 8));
            end
            if (cyc == 1)
                checkOutput("fix grant c1", 64'(grant), 64'h2);
            if (cyc == 5)
                checkOutput("fix grant c5", 64'(grant), 64'h8);
        end
        checkOutput("fix sent", 64'(pkt_sent_cnt), 64'd2);

        // Back-pressure: MAC stalls for 3 cycles while beat 2 is presented.
        startPkt(0, 4, 8'h0F);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            applyStimulus(!(cyc >= 3 && cyc <= 5));
            expValid = (cyc >= 2 && cyc <= 8);
            if (cyc == 2)      expData = beatData(0, 0);
            else if (cyc <= 6) expData = beatData(0, 1);
            else if (cyc == 7) expData = beatData(0, 2);
            else               expData = beatData(0, 3);
            expReady = (cyc <= 2) || cyc == 6 || cyc == 7;
            checkOutput($sformatf("bp valid c%0d", cyc), 64'(m_axis_tvalid), 64'(expValid));
            checkOutput($sformatf("bp tready c%0d", cyc), 64'(s_axis_tready[0]), 64'(expReady));
            if (expValid)
                checkOutput($sformatf("bp data c%0d", cyc), m_axis_tdata, expData);
            if (cyc == 8) begin
                checkOutput("bp keep last", 64'(m_axis_tkeep), 64'h0F);
                checkOutput("bp tlast", 64'(m_axis_tlast), 64'h1);
            end
        end
        checkOutput("bp sent", 64'(pkt_sent_cnt), 64'd3);

        // Loss injection on ch4, mask toggled mid-packet.
        drop_mask[4] = 1'b1;
        startPkt(4, 5, 8'hFF);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("drop valid c%0d", cyc), 64'(m_axis_tvalid), 64'h0);
            checkOutput($sformatf("drop tready c%0d", cyc), 64'(s_axis_tready[4]), 64'(cyc <= 5));
            drop_mask[4] = (cyc % 2 == 0);
        end
        checkOutput("drop cnt", 64'(pkt_drop_cnt), 64'd1);
        checkOutput("drop sent", 64'(pkt_sent_cnt), 64'd3);
        drop_mask = '0;

        // ch2 drops its request and ch0 arrives mid-packet.
        startPkt(2, 4, 8'hFF);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            applyStimulus(1'b1);
            if (cyc == 2) begin
                s_req[2] = 1'b0;
                startPkt(0, 2, 8'hFF);
            end
            if (cyc <= 4)                 expGrant = 5'b00100;
            else if (cyc == 6 || cyc == 7) expGrant = 5'b00001;
            else                          expGrant = 5'b00000;
            expValid = (cyc >= 2 && cyc <= 5) || cyc == 7 || cyc == 8;
            expData  = (cyc <= 5) ? beatData(2, cyc - 2) : beatData(0, cyc - 7);
            checkOutput($sformatf("mid grant c%0d", cyc), 64'(grant), 64'(expGrant));
            checkOutput($sformatf("mid valid c%0d", cyc), 64'(m_axis_tvalid), 64'(expValid));
            if (expValid)
                checkOutput($sformatf("mid data c%0d", cyc), m_axis_tdata, expData);
        end
        checkOutput("mid sent", 64'(pkt_sent_cnt), 64'd5);

        // Asynchronous reset in the middle of a stalled packet.
        startPkt(1, 3, 8'hFF);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("ar pre valid", 64'(m_axis_tvalid), 64'h1);
        aresetn = 1'b0;
        #1;
        checkOutput("ar valid", 64'(m_axis_tvalid), 64'h0);
        checkOutput("ar data", m_axis_tdata, 64'h0);
        checkOutput("ar grant", 64'(grant), 64'h0);
        checkOutput("ar tready", 64'(s_axis_tready), 64'h0);
        checkOutput("ar sent", 64'(pkt_sent_cnt), 64'h0);
        checkOutput("ar drop", 64'(pkt_drop_cnt), 64'h0);
        for (int c = 0; c < NCH; c++)
            src_active[c] = 1'b0;
        s_req = '0;
        driveSources();
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
